// File: rtl/muladd_pkg.sv
// Shared types for the shift-add multiply-accumulate unit.
package muladd_pkg;

  // Controller states: idle/accepting vs. stepping through multiplier bits.
  typedef enum logic {
    RESTING     = 1'b0,
    MULTIPLYING = 1'b1
  } muladd_state_t;

endpackage : muladd_pkg

// File: rtl/muladd.sv
// muladd: computes a*b+c by shift-add, one multiplier bit per clock.
// The inverse of the divider: dividend = quotient*divisor + remainder.
//
// Ports:
//   clk_in           sole clock, rising edge
//   rst_n_in         asynchronous active-low reset
//   multiplicand_in  operand a (unsigned, WIDTH)
//   multiplier_in    operand b (unsigned, WIDTH)
//   addend_in        operand c (unsigned, WIDTH)
//   data_valid_in    request; operands sampled on the accepting edge
//   product_out      low WIDTH bits of a*b+c, held until next completion
//   data_valid_out   one-cycle completion pulse
//   error_out        true result >= 2^WIDTH; valid with data_valid_out
//   busy_out         high while a computation is in progress
module muladd
  import muladd_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] multiplicand_in,
  input  logic [WIDTH-1:0] multiplier_in,
  input  logic [WIDTH-1:0] addend_in,
  input  logic             data_valid_in,
  output logic [WIDTH-1:0] product_out,
  output logic             data_valid_out,
  output logic             error_out,
  output logic             busy_out
);

  // Double-width accumulator so a*b+c never wraps (max 2^(2W) - 2^W).
  localparam int unsigned AW = 2 * WIDTH;

  muladd_state_t    state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             error_q, error_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= RESTING;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      error_q   <= error_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath update; completion pulse defaults low.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    error_d   = error_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      RESTING: begin
        if (data_valid_in) begin
          acc_d    = AW'(addend_in);
          mcand_d  = AW'(multiplicand_in);
          mplier_d = multiplier_in;
          busy_d   = 1'b1;
          error_d  = 1'b0;
          state_d  = MULTIPLYING;
        end
      end
      MULTIPLYING: begin
        // Finishing when no multiplier bits remain gives latency 1 + bitlen(b).
        if (mplier_q == '0) begin
          product_d = acc_q[WIDTH-1:0];
          error_d   = |acc_q[AW-1:WIDTH];
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = RESTING;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
      end
      default: state_d = RESTING;
    endcase
  end

  assign product_out    = product_q;
  assign error_out      = error_q;
  assign data_valid_out = valid_q;
  assign busy_out       = busy_q;

endmodule : muladd
